// File: rtl/dut_degamma_pkg.sv
// dut_degamma_pkg -- shared constants and helpers for the de-gamma stage.
//
// Contents:
//   DEF_IN_DW / DEF_OUT_DW : default channel widths (8-bit in, 12-bit out)
//   MAX_CODE               : output full-scale code
//   KNOT_TABLE             : 17 knots of the 2.2-power curve,
//                            K[i] = round(4095*((16*i)/255)^2.2), K[16] = 4095
//   interp_sum()           : final add of the interpolation, with optional
//                            rounding and saturation at MAX_CODE
//
// Build option: DEGAMMA_ROUND_EN -- when defined the interpolated term is
// rounded to nearest instead of truncated.
package dut_degamma_pkg;

  localparam int DEF_IN_DW  = 8;
  localparam int DEF_OUT_DW = 12;

  localparam logic [11:0] MAX_CODE = 12'd4095;

  localparam logic [11:0] KNOT_TABLE [0:16] = '{
    12'd0,    12'd9,    12'd43,   12'd104,
    12'd196,  12'd320,  12'd477,  12'd670,
    12'd899,  12'd1165, 12'd1469, 12'd1811,
    12'd2193, 12'd2616, 12'd3079, 12'd3584,
    12'd4095
  };

  // base + prod/16, where prod = (K[i+1]-K[i]) * f. Saturates at MAX_CODE.
  function automatic logic [11:0] interp_sum(input logic [11:0] base,
                                             input logic [15:0] prod);
    logic [16:0] prod_adj;
    logic [12:0] sum;
`ifdef DEGAMMA_ROUND_EN
    prod_adj = {1'b0, prod} + 17'd8;
`else
    prod_adj = {1'b0, prod};
`endif
    sum = {1'b0, base} + prod_adj[16:4];
    return (sum > {1'b0, MAX_CODE}) ? MAX_CODE : sum[11:0];
  endfunction

endpackage

// File: rtl/dut_degamma_lut_interp.sv
// degamma_lut_interp -- one colour channel of the de-gamma curve, 3 stages.
//
// Ports:
//   clk       in   pixel clock
//   rstn      in   asynchronous active-low reset
//   x_in      in   8-bit gamma-encoded code (stage 0)
//   en_in     in   1 = apply curve, 0 = bit-replication bypass (stage 0)
//   de_s2_in  in   data enable aligned with this block's stage-2 data;
//                  output is forced to 0 when low
//   y_out     out  12-bit linear code, valid 3 cycles after x_in
//
// Stage 1: register code, fraction, both neighbouring knots and mode.
// Stage 2: multiply the knot difference by the fraction.
// Stage 3: add, apply full-scale override / bypass / DE gating, register.
//
// Build option: DEGAMMA_ROUND_EN (see dut_degamma_pkg::interp_sum).
module degamma_lut_interp
  import dut_degamma_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DEF_IN_DW-1:0]  x_in,
  input  logic                  en_in,
  input  logic                  de_s2_in,
  output logic [DEF_OUT_DW-1:0] y_out
);

  logic [7:0]  x_s1_reg;
  logic [3:0]  f_s1_reg;
  logic [11:0] lo_s1_reg;
  logic [11:0] hi_s1_reg;
  logic        en_s1_reg;

  logic [7:0]  x_s2_reg;
  logic [11:0] lo_s2_reg;
  logic [15:0] prod_s2_reg;
  logic        en_s2_reg;

  logic [11:0] y_reg;

  logic [4:0]  idx_lo;
  logic [4:0]  idx_hi;
  logic [11:0] diff;
  logic [15:0] prod_next;
  logic [11:0] y_next;

  always_comb begin
    idx_lo    = {1'b0, x_in[7:4]};
    idx_hi    = idx_lo + 5'd1;
    // Knots are monotonic, so the difference never wraps.
    diff      = hi_s1_reg - lo_s1_reg;
    prod_next = {4'd0, diff} * {12'd0, f_s1_reg};

    if (!de_s2_in) begin
      y_next = '0;
    end else if (!en_s2_reg) begin
      y_next = {x_s2_reg, x_s2_reg[7:4]};
    end else if (x_s2_reg == 8'hFF) begin
      // 255 lands between K[15] and K[16] with f=15; force true full scale.
      y_next = MAX_CODE;
    end else begin
      y_next = interp_sum(lo_s2_reg, prod_s2_reg);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_s1_reg    <= '0;
      f_s1_reg    <= '0;
      lo_s1_reg   <= '0;
      hi_s1_reg   <= '0;
      en_s1_reg   <= 1'b0;
      x_s2_reg    <= '0;
      lo_s2_reg   <= '0;
      prod_s2_reg <= '0;
      en_s2_reg   <= 1'b0;
      y_reg       <= '0;
    end else begin
      x_s1_reg    <= x_in;
      f_s1_reg    <= x_in[3:0];
      lo_s1_reg   <= KNOT_TABLE[idx_lo];
      hi_s1_reg   <= KNOT_TABLE[idx_hi];
      en_s1_reg   <= en_in;
      x_s2_reg    <= x_s1_reg;
      lo_s2_reg   <= lo_s1_reg;
      prod_s2_reg <= prod_next;
      en_s2_reg   <= en_s1_reg;
      y_reg       <= y_next;
    end
  end

  assign y_out = y_reg;

endmodule

// File: rtl/dut_degamma.sv
// dut_degamma -- pixel-domain de-gamma: 8-bit gamma RGB in, 12-bit linear out.
//
// Ports:
//   clk             in   pixel clock
//   rstn            in   asynchronous active-low reset
//   vsync_in        in   frame sync, active high
//   de_in           in   data enable, active high
//   r_in/g_in/b_in  in   IN_DW-bit gamma-encoded pixel
//   reg_degamma_en  in   1 = apply curve, 0 = bypass; taken only at the
//                        rising edge of vsync_in and held for that frame
//   vsync_out       out  vsync_in delayed 3 cycles
//   de_out          out  de_in delayed 3 cycles
//   r_out/g_out/b_out out OUT_DW-bit linear pixel, 0 whenever de_out is 0
//
// Fixed 3-cycle latency, one pixel per clock, no backpressure. The curve
// table is built for 8-bit in / 12-bit out; other widths are rejected at
// elaboration. Output geometry must equal input geometry; the timing
// parameters are informational only.
//
// Build option: DEGAMMA_ROUND_EN -- round instead of truncate when
// interpolating between knots.
module dut_degamma
  import dut_degamma_pkg::*;
#(
  parameter int IN_DW           = DEF_IN_DW,
  parameter int OUT_DW          = DEF_OUT_DW,
  parameter int MAXIMUM         = 4095,
  parameter int IN_WIDTH        = 24,
  parameter int IN_HEIGHT       = 36,
  parameter int I_VSYNC_WIDTH   = 1,
  parameter int I_V_BACK_PORCH  = 1,
  parameter int I_V_FRONT_PORCH = 1,
  parameter int I_HSYNC_WIDTH   = 1,
  parameter int I_H_BACK_PORCH  = 10,
  parameter int I_H_FRONT_PORCH = 10,
  parameter int OUT_WIDTH       = 24,
  parameter int OUT_HEIGHT      = 36,
  parameter int O_VSYNC_WIDTH   = 1,
  parameter int O_V_BACK_PORCH  = 1,
  parameter int O_V_FRONT_PORCH = 1,
  parameter int O_HSYNC_WIDTH   = 1,
  parameter int O_H_BACK_PORCH  = 6,
  parameter int O_H_FRONT_PORCH = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vsync_in,
  input  logic              de_in,
  input  logic [IN_DW-1:0]  r_in,
  input  logic [IN_DW-1:0]  g_in,
  input  logic [IN_DW-1:0]  b_in,
  input  logic              reg_degamma_en,
  output logic              vsync_out,
  output logic              de_out,
  output logic [OUT_DW-1:0] r_out,
  output logic [OUT_DW-1:0] g_out,
  output logic [OUT_DW-1:0] b_out
);

  localparam bit CFG_OK =
      (IN_DW == DEF_IN_DW) && (OUT_DW == DEF_OUT_DW) &&
      (MAXIMUM == (1 << OUT_DW) - 1) &&
      (OUT_WIDTH == IN_WIDTH) && (OUT_HEIGHT == IN_HEIGHT) &&
      (I_VSYNC_WIDTH >= 0) && (I_V_BACK_PORCH >= 0) && (I_V_FRONT_PORCH >= 0) &&
      (I_HSYNC_WIDTH >= 0) && (I_H_BACK_PORCH >= 0) && (I_H_FRONT_PORCH >= 0) &&
      (O_VSYNC_WIDTH >= 0) && (O_V_BACK_PORCH >= 0) && (O_V_FRONT_PORCH >= 0) &&
      (O_HSYNC_WIDTH >= 0) && (O_H_BACK_PORCH >= 0) && (O_H_FRONT_PORCH >= 0);

  if (!CFG_OK) begin : g_cfg_error
    $error("dut_degamma: unsupported width/geometry configuration");
  end

  logic       vsync_prev_reg;
  logic       en_frame_reg;
  logic [2:0] vsync_dly_reg;
  logic [2:0] de_dly_reg;

  logic vsync_rise;
  logic en_pix;

  logic [DEF_IN_DW-1:0]  x_ch [3];
  logic [DEF_OUT_DW-1:0] y_ch [3];

  assign vsync_rise = vsync_in & ~vsync_prev_reg;
  // A pixel sampled on the frame-start edge already uses the new mode.
  assign en_pix     = vsync_rise ? reg_degamma_en : en_frame_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_prev_reg <= 1'b0;
      en_frame_reg   <= 1'b0;
      vsync_dly_reg  <= '0;
      de_dly_reg     <= '0;
    end else begin
      vsync_prev_reg <= vsync_in;
      if (vsync_rise) begin
        en_frame_reg <= reg_degamma_en;
      end
      vsync_dly_reg <= {vsync_dly_reg[1:0], vsync_in};
      de_dly_reg    <= {de_dly_reg[1:0], de_in};
    end
  end

  assign x_ch[0] = r_in;
  assign x_ch[1] = g_in;
  assign x_ch[2] = b_in;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    degamma_lut_interp u_interp (
      .clk      (clk),
      .rstn     (rstn),
      .x_in     (x_ch[gi]),
      .en_in    (en_pix),
      .de_s2_in (de_dly_reg[1]),
      .y_out    (y_ch[gi])
    );
  end

  assign r_out     = y_ch[0];
  assign g_out     = y_ch[1];
  assign b_out     = y_ch[2];
  assign vsync_out = vsync_dly_reg[2];
  assign de_out    = de_dly_reg[2];

endmodule

// File: tb/tb_dut_degamma.sv
// Self-checking bench for dut_degamma: directed curve points, then random
// frames (random pixels, random mid-frame enable toggles), an asynchronous
// reset in the middle of a line, and a clean frame afterwards.
module tb_dut_degamma;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        vsync_in = 1'b0;
  logic        de_in = 1'b0;
  logic [7:0]  r_in = '0;
  logic [7:0]  g_in = '0;
  logic [7:0]  b_in = '0;
  logic        reg_degamma_en = 1'b0;
  logic        vsync_out;
  logic        de_out;
  logic [11:0] r_out;
  logic [11:0] g_out;
  logic [11:0] b_out;

  always #5 clk = ~clk;

  dut_degamma dut (
    .clk            (clk),
    .rstn           (rstn),
    .vsync_in       (vsync_in),
    .de_in          (de_in),
    .r_in           (r_in),
    .g_in           (g_in),
    .b_in           (b_in),
    .reg_degamma_en (reg_degamma_en),
    .vsync_out      (vsync_out),
    .de_out         (de_out),
    .r_out          (r_out),
    .g_out          (g_out),
    .b_out          (b_out)
  );

  typedef struct {
    int vs;
    int de;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t hist[$];
  int   knot [17];
  int   n_cmp = 0;
  int   n_err = 0;
  int   en_model = 0;
  int   vs_prev_model = 0;
  bit   release_pending = 1'b0;
  int   act_cnt = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference curve straight from the definition: power-law knots and
  // linear interpolation between them.
  function automatic int ref_pix(input int x, input int en);
    int i;
    int f;
    int y;
    if (en == 0) return x * 16 + x / 16;
    if (x == 255) return 4095;
    i = x / 16;
    f = x % 16;
`ifdef DEGAMMA_ROUND_EN
    y = knot[i] + ((knot[i+1] - knot[i]) * f + 8) / 16;
`else
    y = knot[i] + ((knot[i+1] - knot[i]) * f) / 16;
`endif
    return (y > 4095) ? 4095 : y;
  endfunction

  function automatic int rand_px();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return 255;
    if (s == 1) return 16 * $urandom_range(0, 15);
    return $urandom_range(0, 255);
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{0, 0, 0, 0, 0};
    return e;
  endfunction

  // One clock: check outputs against the entry queued three cycles ago,
  // then drive the next inputs and queue their expected result.
  // lit >= 0 replaces the model value with a literal expected code.
  task automatic drive_cycle(input int vs, input int de, input int r,
                             input int g, input int b, input int en,
                             input int lit);
    exp_t e;
    @(posedge clk);
    #1;
    e = hist.pop_front();
    check_val("vsync_out", int'(vsync_out), e.vs);
    check_val("de_out", int'(de_out), e.de);
    check_val("r_out", int'(r_out), e.r);
    check_val("g_out", int'(g_out), e.g);
    check_val("b_out", int'(b_out), e.b);
    if (de_out) act_cnt++;
    if (release_pending) begin
      rstn = 1'b1;
      release_pending = 1'b0;
    end
    vsync_in       = vs[0];
    de_in          = de[0];
    r_in           = r[7:0];
    g_in           = g[7:0];
    b_in           = b[7:0];
    reg_degamma_en = en[0];
    if (!rstn) begin
      e = zero_exp();
    end else begin
      if (vs != 0 && vs_prev_model == 0) en_model = en;
      vs_prev_model = vs;
      e.vs = vs;
      e.de = de;
      if (de == 0) begin
        e.r = 0;
        e.g = 0;
        e.b = 0;
      end else if (lit >= 0) begin
        e.r = lit;
        e.g = lit;
        e.b = lit;
      end else begin
        e.r = ref_pix(r, en_model);
        e.g = ref_pix(g, en_model);
        e.b = ref_pix(b, en_model);
      end
    end
    hist.push_back(e);
  endtask

  // Frame start with the requested mode; enable then flips while vsync is
  // still high and after it falls, neither of which may change the mode.
  task automatic set_mode(input int en);
    drive_cycle(1, 0, 0, 0, 0, en, -1);
    drive_cycle(1, 0, 0, 0, 0, 1 - en, -1);
    drive_cycle(0, 0, 0, 0, 0, 1 - en, -1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(0, 0, 0, 0, 0, reg_degamma_en, -1);
  endtask

  // 24x36 frame, 45-cycle lines (1 sync + 10 back + 24 active + 10 front),
  // 39 lines (1 vsync + 1 back + 36 active + 1 front). Stops at column 20
  // of line stop_line when stop_line < 39.
  task automatic run_frame(input int fidx, input int stop_line);
    int en_req;
    int vs;
    int de;
    act_cnt = 0;
    en_req = $urandom_range(0, 1);
    for (int ln = 0; ln < 39; ln++) begin
      if (ln > 0 && $urandom_range(0, 2) == 0) en_req = $urandom_range(0, 1);
      for (int col = 0; col < 45; col++) begin
        if (ln == stop_line && col == 20) return;
        vs = (ln == 0) ? 1 : 0;
        de = (ln >= 2 && ln <= 37 && col >= 11 && col <= 34) ? 1 : 0;
        drive_cycle(vs, de, rand_px(), rand_px(), rand_px(), en_req, -1);
      end
    end
    check_val("active_pixels", act_cnt, 864);
    $display("frame %0d: active_out=%0d mode=%0d", fidx, act_cnt, en_model);
  endtask

  int dir_x [5] = '{0, 16, 128, 255, 8};
`ifdef DEGAMMA_ROUND_EN
  int dir_y [5] = '{0, 9, 899, 4095, 5};
`else
  int dir_y [5] = '{0, 9, 899, 4095, 4};
`endif
  int byp_x [2] = '{128, 255};
  int byp_y [2] = '{2056, 4095};

  initial begin
    for (int i = 0; i < 16; i++) begin
      knot[i] = $rtoi(4095.0 * $pow((16.0 * i) / 255.0, 2.2) + 0.5);
    end
    knot[16] = 4095;
    for (int k = 0; k < 3; k++) hist.push_back(zero_exp());

    // Reset state.
    #2 rstn = 1'b0;
    #1;
    check_val("reset_vsync_out", int'(vsync_out), 0);
    check_val("reset_de_out", int'(de_out), 0);
    check_val("reset_r_out", int'(r_out), 0);
    check_val("reset_g_out", int'(g_out), 0);
    check_val("reset_b_out", int'(b_out), 0);
    release_pending = 1'b1;

    // Directed curve points, enable on.
    set_mode(1);
    for (int k = 0; k < 5; k++) begin
      drive_cycle(0, 1, dir_x[k], dir_x[k], dir_x[k], 0, dir_y[k]);
      $display("curve x=%0d expect=%0d", dir_x[k], dir_y[k]);
    end
    idle(4);

    // Directed bypass points.
    set_mode(0);
    for (int k = 0; k < 2; k++) begin
      drive_cycle(0, 1, byp_x[k], byp_x[k], byp_x[k], 1, byp_y[k]);
      $display("bypass x=%0d expect=%0d", byp_x[k], byp_y[k]);
    end
    idle(5);

    // Random frames.
    for (int fr = 0; fr < 3; fr++) run_frame(fr, 39);

    // Asynchronous reset in the middle of an active line.
    run_frame(3, 20);
    #2 rstn = 1'b0;
    #1;
    check_val("async_rst_vsync_out", int'(vsync_out), 0);
    check_val("async_rst_de_out", int'(de_out), 0);
    check_val("async_rst_r_out", int'(r_out), 0);
    check_val("async_rst_g_out", int'(g_out), 0);
    check_val("async_rst_b_out", int'(b_out), 0);
    $display("reset asserted mid-line at t=%0t", $time);
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back(zero_exp());
    en_model = 0;
    vs_prev_model = 0;
    idle(2);
    release_pending = 1'b1;
    // No frame start yet: bypass must apply even with enable requested.
    for (int k = 0; k < 6; k++) drive_cycle(0, 1, rand_px(), rand_px(), rand_px(), 1, -1);
    idle(4);

    run_frame(4, 39);
    run_frame(5, 39);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
